// File: rtl/awb_pkg.sv
// Shared AWB definitions: fixed-point format of the channel means and the stats FSM states.
package awb_pkg;
  localparam int FRAC_W = 16;
  localparam int MEAN_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    DIV_R,
    DIV_G,
    DIV_B,
    UPDATE
  } awb_state_e;
endpackage

// File: rtl/awb_serial_div.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses DVD_W+1 cycles after start.
module awb_serial_div #(
  parameter int DVD_W = 46,
  parameter int DVS_W = 22
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic             done
);
  localparam int CW = $clog2(DVD_W + 1);

  // dq_q shifts the dividend out at the top while quotient bits enter at the bottom
  logic [DVD_W-1:0] dq_q, dq_d;
  logic [DVS_W-1:0] rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [DVS_W:0]   trial;

  always_comb begin
    dq_d   = dq_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    trial  = {rem_q, dq_q[DVD_W-1]};
    if (start) begin
      dq_d  = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = CW'(DVD_W);
    end else if (cnt_q != '0) begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = DVS_W'(trial - {1'b0, dvs_q});
        dq_d  = {dq_q[DVD_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DVS_W-1:0];
        dq_d  = {dq_q[DVD_W-2:0], 1'b0};
      end
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dq_q   <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      dq_q   <= dq_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quotient = dq_q;
  assign done     = done_q;
endmodule

// File: rtl/awb_channel_stats.sv
// Per-frame R/G/B accumulation of unsaturated pixels; at vsync fall the sums are snapshotted
// and divided by the pixel count to publish 16.16 channel means during the next frame.
module awb_channel_stats
  import awb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 22,
  parameter int SAT_TH = 250
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic              de,
  input  logic [DATA_W-1:0] pix_R,
  input  logic [DATA_W-1:0] pix_G,
  input  logic [DATA_W-1:0] pix_B,
  output logic [MEAN_W-1:0] mean_R,
  output logic [MEAN_W-1:0] mean_G,
  output logic [MEAN_W-1:0] mean_B,
  output logic [CNT_W-1:0]  pixel_count,
  output logic              mean_valid,
  output logic              busy
);
  localparam int SUM_W = DATA_W + CNT_W;
  localparam int DW    = SUM_W + FRAC_W;
  localparam logic [DATA_W:0]  SAT_V   = (DATA_W + 1)'(SAT_TH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  awb_state_e        state_q, state_d;
  logic              vsync_q, rise, fall, pix_ok, acc, cnt_zero;
  logic [SUM_W-1:0]  sum_r_q, sum_g_q, sum_b_q, snap_r_q, snap_g_q, snap_b_q, div_sum;
  logic [CNT_W-1:0]  cnt_q, snap_cnt_q, pcnt_q;
  logic [MEAN_W-1:0] temp_r_q, temp_g_q, mean_r_q, mean_g_q, mean_b_q, quot_mean;
  logic              issued_q, div_start, div_done, div_ack;
  logic [DW-1:0]     div_quot;

  assign rise     = vsync & ~vsync_q;
  assign fall     = ~vsync & vsync_q;
  assign pix_ok   = ({1'b0, pix_R} < SAT_V) && ({1'b0, pix_G} < SAT_V) && ({1'b0, pix_B} < SAT_V);
  assign acc      = vsync & vsync_q & de & pix_ok & (cnt_q != CNT_MAX);
  assign cnt_zero = (cnt_q == '0);
  // A done only belongs to the current state once that state has issued its own start
  assign div_ack   = div_done & issued_q;
  assign quot_mean = MEAN_W'(div_quot);

  always_comb begin
    div_sum = snap_r_q;
    case (state_q)
      DIV_G:   div_sum = snap_g_q;
      DIV_B:   div_sum = snap_b_q;
      default: div_sum = snap_r_q;
    endcase
  end

  awb_serial_div #(
    .DVD_W(DW),
    .DVS_W(CNT_W)
  ) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (div_start),
    .dividend({div_sum, {FRAC_W{1'b0}}}),
    .divisor (snap_cnt_q),
    .quotient(div_quot),
    .done    (div_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (fall) begin
      state_d = cnt_zero ? UPDATE : DIV_R;
    end else begin
      case (state_q)
        DIV_R:   if (div_ack) state_d = DIV_G;
        DIV_G:   if (div_ack) state_d = DIV_B;
        DIV_B:   if (div_ack) state_d = UPDATE;
        UPDATE:  state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != IDLE);
    mean_valid = (state_q == UPDATE);
    div_start  = 1'b0;
    if (state_q == DIV_R || state_q == DIV_G || state_q == DIV_B) div_start = ~issued_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vsync_q    <= 1'b0;
      sum_r_q    <= '0;
      sum_g_q    <= '0;
      sum_b_q    <= '0;
      cnt_q      <= '0;
      snap_r_q   <= '0;
      snap_g_q   <= '0;
      snap_b_q   <= '0;
      snap_cnt_q <= '0;
      issued_q   <= 1'b0;
      temp_r_q   <= '0;
      temp_g_q   <= '0;
      mean_r_q   <= '0;
      mean_g_q   <= '0;
      mean_b_q   <= '0;
      pcnt_q     <= '0;
    end else begin
      vsync_q <= vsync;
      if (rise) begin
        sum_r_q <= '0;
        sum_g_q <= '0;
        sum_b_q <= '0;
        cnt_q   <= '0;
      end else if (acc) begin
        sum_r_q <= sum_r_q + SUM_W'(pix_R);
        sum_g_q <= sum_g_q + SUM_W'(pix_G);
        sum_b_q <= sum_b_q + SUM_W'(pix_B);
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (fall) begin
        snap_r_q   <= sum_r_q;
        snap_g_q   <= sum_g_q;
        snap_b_q   <= sum_b_q;
        snap_cnt_q <= cnt_q;
      end
      if (fall || state_d != state_q) issued_q <= 1'b0;
      else if (div_start)             issued_q <= 1'b1;
      if (div_ack && !fall && state_q == DIV_R) temp_r_q <= quot_mean;
      if (div_ack && !fall && state_q == DIV_G) temp_g_q <= quot_mean;
      // Means change only on entry to UPDATE so the published triplet is always consistent
      if (fall && cnt_zero) begin
        mean_r_q <= '0;
        mean_g_q <= '0;
        mean_b_q <= '0;
        pcnt_q   <= '0;
      end else if (div_ack && !fall && state_q == DIV_B) begin
        mean_r_q <= temp_r_q;
        mean_g_q <= temp_g_q;
        mean_b_q <= quot_mean;
        pcnt_q   <= snap_cnt_q;
      end
    end
  end

  assign mean_R      = mean_r_q;
  assign mean_G      = mean_g_q;
  assign mean_B      = mean_b_q;
  assign pixel_count = pcnt_q;
endmodule

// File: tb/tb_awb_channel_stats.sv
// Bench for awb_channel_stats: pixel driver with a reference model, expected-result queue
// checked on every mean_valid, plus a CNT_W=4 instance for counter saturation.
module tb_awb_channel_stats;
  localparam int CNT_W = 22;

  logic             clk = 1'b0;
  logic             reset_n, vsync, de;
  logic [7:0]       pix_R, pix_G, pix_B;
  logic [31:0]      mean_R, mean_G, mean_B;
  logic [CNT_W-1:0] pixel_count;
  logic             mean_valid, busy;
  logic [31:0]      mean_R4, mean_G4, mean_B4;
  logic [3:0]       pixel_count4;
  logic             mean_valid4, busy4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_fall = 0;
  logic [127:0] exp_q[$];
  int           exp_t_q[$];
  logic [127:0] pub_e = '0;
  longint       m_r, m_g, m_b;
  int           m_cnt;

  awb_channel_stats dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .de(de),
    .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B),
    .mean_R(mean_R), .mean_G(mean_G), .mean_B(mean_B),
    .pixel_count(pixel_count), .mean_valid(mean_valid), .busy(busy)
  );

  awb_channel_stats #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .de(de),
    .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B),
    .mean_R(mean_R4), .mean_G(mean_G4), .mean_B(mean_B4),
    .pixel_count(pixel_count4), .mean_valid(mean_valid4), .busy(busy4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every mean_valid pops one expected triplet and its expected cycle
  always @(negedge clk) begin
    logic [127:0] e;
    int et;
    if (mean_valid !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mean_valid cyc=%0d mean_valid=%b", cyc, mean_valid);
      end else begin
        e  = exp_q.pop_front();
        et = exp_t_q.pop_front();
        pub_e = e;
        if ({mean_R, mean_G, mean_B, 32'(pixel_count)} !== e) begin
          errors++;
          $display("FAIL means got R=%h G=%h B=%h cnt=%0d exp R=%h G=%h B=%h cnt=%0d",
                   mean_R, mean_G, mean_B, pixel_count, e[127:96], e[95:64], e[63:32], e[31:0]);
        end
        checks++;
        if (cyc != et) begin
          errors++;
          $display("FAIL update_cycle got %0d exp %0d", cyc, et);
        end
      end
    end
  end

  task automatic drive_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(negedge clk);
    de = 1'b1; pix_R = r; pix_G = g; pix_B = b;
    if (r < 250 && g < 250 && b < 250) begin
      m_r += r; m_g += g; m_b += b; m_cnt++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      de = 1'b0;
    end
  endtask

  task automatic frame_start();
    @(negedge clk);
    vsync = 1'b1; de = 1'b0;
    m_r = 0; m_g = 0; m_b = 0; m_cnt = 0;
  endtask

  task automatic frame_end(input bit publish);
    logic [127:0] e;
    @(negedge clk);
    de = 1'b0; vsync = 1'b0; t_fall = cyc;
    if (publish) begin
      if (m_cnt == 0) begin
        e = '0;
        exp_t_q.push_back(t_fall + 1);
      end else begin
        e = {32'((m_r << 16) / m_cnt), 32'((m_g << 16) / m_cnt), 32'((m_b << 16) / m_cnt), 32'(m_cnt)};
        exp_t_q.push_back(t_fall + 145);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
      exp_q.delete();
      exp_t_q.delete();
    end
  endtask

  task automatic check_hold(input string name);
    checks++;
    if ({mean_R, mean_G, mean_B, 32'(pixel_count)} !== pub_e || mean_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s got R=%h G=%h B=%h cnt=%0d v=%b exp R=%h G=%h B=%h cnt=%0d v=0", name,
               mean_R, mean_G, mean_B, pixel_count, mean_valid,
               pub_e[127:96], pub_e[95:64], pub_e[63:32], pub_e[31:0]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({mean_R, mean_G, mean_B, pixel_count, mean_valid, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got R=%h G=%h B=%h cnt=%0d v=%b busy=%b exp all 0",
               mean_R, mean_G, mean_B, pixel_count, mean_valid, busy);
    end
    reset_n = 1'b1;
    idle(3);
    check_hold("post_reset_idle");
  endtask

  task automatic test_uniform();
    frame_start();
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) drive_pix(8'd100, 8'd200, 8'd50);
      idle(2);
    end
    frame_end(1'b1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_at_T+1 got %b exp 1", busy);
    end
    wait_drain();
    checks++;
    if (pub_e !== {32'h00640000, 32'h00C80000, 32'h00320000, 32'd16}) begin
      errors++;
      $display("FAIL uniform_published got %h exp 00640000 00C80000 00320000 cnt 16", pub_e);
    end
    idle(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_update got %b exp 0", busy);
    end
    idle(10);
    check_hold("uniform_hold");
  endtask

  task automatic test_saturation();
    frame_start();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) drive_pix(8'd80, 8'd255, 8'd80);
      else            drive_pix(8'd80, 8'd80, 8'd80);
    end
    frame_end(1'b1);
    wait_drain();
    checks++;
    if (pub_e !== {32'h00500000, 32'h00500000, 32'h00500000, 32'd4}) begin
      errors++;
      $display("FAIL saturation_published got %h exp 00500000 x3 cnt 4", pub_e);
    end
  endtask

  task automatic test_sat_boundary();
    frame_start();
    drive_pix(8'd249, 8'd249, 8'd249);
    drive_pix(8'd250, 8'd0, 8'd0);
    drive_pix(8'd0, 8'd250, 8'd0);
    drive_pix(8'd0, 8'd0, 8'd250);
    drive_pix(8'd0, 8'd0, 8'd0);
    frame_end(1'b1);
    wait_drain();
  endtask

  task automatic test_empty();
    frame_start();
    idle(12);
    frame_end(1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL empty_frame busy=%b pending=%0d exp busy=0 pending=0", busy, exp_q.size());
    end
    wait_drain();
  endtask

  task automatic test_cnt_sat();
    int n = 0;
    frame_start();
    repeat (20) drive_pix(8'd200, 8'd200, 8'd200);
    frame_end(1'b1);
    while (mean_valid4 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mean_valid4 !== 1'b1) begin
      errors++;
      $display("FAIL cnt_sat_timeout got no mean_valid exp pulse");
    end else begin
      checks++;
      if (mean_R4 !== 32'h00C80000 || pixel_count4 !== 4'd15 || cyc != t_fall + 91) begin
        errors++;
        $display("FAIL cnt_sat got R=%h cnt=%0d cyc=%0d exp R=00C80000 cnt=15 cyc=%0d",
                 mean_R4, pixel_count4, cyc, t_fall + 91);
      end
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      frame_start();
      for (int i = 0; i < 60 + f * 100; i++) begin
        if ($urandom_range(0, 3) != 0)
          drive_pix(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        else
          idle(1);
      end
      frame_end(1'b1);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int t;
    frame_start();
    for (int i = 0; i < 10; i++) drive_pix(8'(i * 7), 8'(i * 3), 8'(i * 11));
    frame_end(1'b0);
    t = t_fall;
    while (cyc < t + 49) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({mean_R, mean_G, mean_B, pixel_count, mean_valid, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid got R=%h G=%h B=%h cnt=%0d v=%b busy=%b exp all 0",
               mean_R, mean_G, mean_B, pixel_count, mean_valid, busy);
    end
    reset_n = 1'b1;
    pub_e = '0;
    idle(150);
    check_hold("reset_mid_no_publish");
  endtask

  task automatic test_refall();
    int t;
    int t2;
    frame_start();
    repeat (16) drive_pix(8'd100, 8'd200, 8'd50);
    frame_end(1'b1);
    wait_drain();
    frame_start();
    for (int i = 0; i < 5; i++) drive_pix(8'd10, 8'd20, 8'd30);
    frame_end(1'b0);
    t = t_fall;
    while (cyc < t + 49) @(negedge clk);
    frame_start();
    drive_pix(8'd1, 8'd1, 8'd1);
    drive_pix(8'd1, 8'd1, 8'd1);
    drive_pix(8'd2, 8'd1, 8'd1);
    while (cyc < t + 59) idle(1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL refall_busy got %b exp 1", busy);
    end
    check_hold("refall_hold_before");
    frame_end(1'b1);
    t2 = t_fall;
    while (cyc < t2 + 100) @(negedge clk);
    check_hold("refall_hold_after");
    wait_drain();
    checks++;
    if (pub_e !== {32'h00015555, 32'h00010000, 32'h00010000, 32'd3}) begin
      errors++;
      $display("FAIL refall_published got %h exp 00015555 00010000 00010000 cnt 3", pub_e);
    end
  endtask

  initial begin
    reset_n = 1'b0; vsync = 1'b0; de = 1'b0;
    pix_R = '0; pix_G = '0; pix_B = '0;
    m_r = 0; m_g = 0; m_b = 0; m_cnt = 0;
    test_reset();
    test_uniform();
    test_saturation();
    test_sat_boundary();
    test_empty();
    test_cnt_sat();
    test_back_to_back();
    test_reset_mid();
    test_refall();
    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
